// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Start/done handshake and operand/result bundle for the
//                bit-serial adder. The requester drives the master side and
//                the adder presents the slave side.
//  Signals     : start, a, b, c_in         (master -> slave)
//                busy, done, s, c_out, ovf (slave  -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, s, c_out, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial ripple adder, LSB first. A single full-adder cell
//                feeds a carry flip-flop and one bit is processed per clock.
//                Computes a + b + c_in modulo 2^WIDTH with the carry on c_out.
//                An operation takes WIDTH+2 cycles from start to next start.
//  Ports       : clk   - rising-edge clock
//                rst   - synchronous reset, active-high
//                bus   - serial_adder_if.slave
//                        start/a/b/c_in in, busy/done/s/c_out/ovf out
//  Options     : SERIAL_ADDER_OVF_EN - when defined, ovf reports signed
//                overflow of the last completed operation; otherwise ovf is
//                a constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_adder_if.slave  bus
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_sb;
    logic             w_cb;
    logic [WIDTH-1:0] w_res_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode. busy and done are registered from these so
    // that they change on the same edge as the state transitions.
    // ------------------------------------------------------------------
    always_comb begin
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_last     = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_load     = bus.start;
                w_busy_nxt = bus.start;
            end
            c_RUN: begin
                w_step     = 1'b1;
                w_last     = (r_cnt == c_LAST);
                w_busy_nxt = (r_cnt != c_LAST);
                w_done_nxt = (r_cnt == c_LAST);
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Full-adder cell on the current LSBs and the carry flip-flop
    assign w_sb      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cb      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB
    assign w_res_nxt = {w_sb, r_res[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_s     <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.c_in;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_res   <= w_res_nxt;
                r_carry <= w_cb;
                if (w_last) begin
                    // Results update only on completion; start alone keeps them
                    r_s     <= w_res_nxt;
                    r_c_out <= w_cb;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.s     = r_s;
    assign bus.c_out = r_c_out;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the MSB step r_carry is the carry into the sign bit; overflow is
    // when it differs from the carry out of the sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_cb;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule
`default_nettype wire
